// File: rtl/output_buffer_ctrl.sv
// rtl/output_buffer_ctrl.sv - tile output buffer: skewed writeback fill, in-order row drain via 2-entry skid FIFO
// Optional feature: define OB_CTRL_STALL_CNT_EN to add the stall_cnt output.
module output_buffer_ctrl #(
    parameter int ROWS  = 16,
    parameter int LANES = 16
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                start,
    output logic                busy,
    output logic                done,
    input  logic                wr_valid,
    output logic                wr_ready,
    input  logic [64*LANES-1:0] wr_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [64*LANES-1:0] out_data,
    output logic                CEN,
    output logic                WEN,
    output logic [12:0]         A,
    output logic [64*LANES-1:0] D,
    output logic                RETN,
    input  logic [64*LANES-1:0] Q
`ifdef OB_CTRL_STALL_CNT_EN
    ,
    output logic [15:0]         stall_cnt
`endif
);
    localparam int DW    = 64 * LANES;
    localparam int CW    = $clog2(ROWS + LANES);
    localparam int BEATS = ROWS + LANES - 1;

    typedef enum logic [1:0] {IDLE, FILL, DRAIN, DONE} state_t;
    state_t state, state_nxt;

    logic [CW-1:0] wr_cnt, rd_cnt, out_cnt;
    logic [DW-1:0] fifo_mem [2];
    logic          fifo_head;
    logic [1:0]    fifo_cnt;
    logic          inflight;
    logic          tile_start, wr_fire, rd_issue, pop, last_beat, last_row;
    logic [2:0]    credit;

    always_comb begin
        tile_start = (state == IDLE) && start;
        busy       = !RST && (state != IDLE);
        done       = !RST && (state == DONE);
        RETN       = !RST;
        wr_ready   = !RST && (state == FILL);
        wr_fire    = wr_ready && wr_valid;
        last_beat  = wr_fire && (wr_cnt == CW'(BEATS - 1));
        out_valid  = !RST && (fifo_cnt != 2'd0);
        out_data   = out_valid ? fifo_mem[fifo_head] : '0;
        pop        = out_valid && out_ready;
        last_row   = pop && (out_cnt == CW'(ROWS - 1));
        // A slot leaving this cycle frees room for a read whose data lands two edges later.
        credit     = 3'(fifo_cnt) + 3'(inflight) - 3'(pop);
        rd_issue   = !RST && (state == DRAIN) && (rd_cnt != CW'(ROWS)) && (credit < 3'd2);

        CEN = 1'b1;
        WEN = 1'b1;
        A   = '0;
        D   = '0;
        if (wr_fire) begin
            CEN = 1'b0;
            WEN = 1'b0;
            A   = 13'(wr_cnt);
            D   = wr_data;
        end else if (rd_issue) begin
            CEN = 1'b0;
            A   = 13'(rd_cnt);
        end

        state_nxt = state;
        case (state)
            IDLE:    if (start)     state_nxt = FILL;
            FILL:    if (last_beat) state_nxt = DRAIN;
            DRAIN:   if (last_row)  state_nxt = DONE;
            DONE:                   state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            wr_cnt    <= '0;
            rd_cnt    <= '0;
            out_cnt   <= '0;
            fifo_head <= 1'b0;
            fifo_cnt  <= 2'd0;
            inflight  <= 1'b0;
        end else begin
            state    <= state_nxt;
            inflight <= rd_issue;
            fifo_cnt <= fifo_cnt + 2'(inflight) - 2'(pop);
            if (pop) fifo_head <= ~fifo_head;
            if (tile_start) begin
                wr_cnt  <= '0;
                rd_cnt  <= '0;
                out_cnt <= '0;
            end else begin
                if (wr_fire)  wr_cnt  <= wr_cnt + CW'(1);
                if (rd_issue) rd_cnt  <= rd_cnt + CW'(1);
                if (pop)      out_cnt <= out_cnt + CW'(1);
            end
        end
    end

    // Q is only trusted the cycle after a read this controller issued since the last reset.
    always_ff @(posedge CLK) begin
        if (!RST && inflight) fifo_mem[fifo_head ^ fifo_cnt[0]] <= Q;
    end

`ifdef OB_CTRL_STALL_CNT_EN
    always_ff @(posedge CLK) begin
        if (RST || tile_start) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif
endmodule
